// File: rtl/tmr_reint_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmr_reint_sched_if : control-unit / BIST side signals of the TMR      |
// | re-integration scheduler.                       rev 1.0               |
// +----------------------------------------------------------------------+
interface tmr_reint_sched_if;
    logic       active;
    logic [2:0] dis_mask;
    logic       test_ack;
    logic       test_done;
    logic       test_pass;
    logic       test_req;
    logic [2:0] test_sel;
    logic       test_abort;
    logic [2:0] reint;
    logic [2:0] retired;
    logic       busy;

    modport master (
        input  active, dis_mask, test_ack, test_done, test_pass,
        output test_req, test_sel, test_abort, reint, retired, busy
    );

    modport slave (
        output active, dis_mask, test_ack, test_done, test_pass,
        input  test_req, test_sel, test_abort, reint, retired, busy
    );
endinterface
`default_nettype wire

// File: rtl/tmr_reint_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmr_reint_sched : round-robin BIST scheduler that re-integrates or    |
// | retires disabled TMR modules.                   rev 1.0               |
// +----------------------------------------------------------------------+
module tmr_reint_sched #(
    parameter int PASS_NEEDED = 3,
    parameter int MAX_FAILS   = 4,
    parameter int COOLDOWN    = 16,
    parameter int TIMEOUT     = 64
) (
    input wire logic          clk,
    input wire logic          rst,
    tmr_reint_sched_if.master bus
);
    localparam int TMAX = (TIMEOUT > COOLDOWN) ? TIMEOUT : COOLDOWN;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RUN_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN - 1);
    localparam logic [3:0]    PASS_LAST = 4'(PASS_NEEDED - 1);
    localparam logic [3:0]    FAIL_LAST = 4'(MAX_FAILS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RUN  = 3'd2,
        EVAL = 3'd3,
        COOL = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [1:0]      cur, rr_ptr, pick;
    logic            pick_ok;
    logic [TW-1:0]   timer;
    logic            res;
    logic [3:0]      pass_cnt [0:2];
    logic [3:0]      fail_cnt [0:2];
    logic [2:0]      retired_q;
    logic [2:0]      cand, cur_oh;
    logic            abort;
    logic            test_req, test_abort;
    logic [2:0]      test_sel, reint;

    assign cand   = bus.dis_mask & ~retired_q;
    assign cur_oh = 3'b001 << cur;
    assign abort  = ((state == REQ) || (state == RUN)) &&
                    (bus.active || !bus.dis_mask[cur]);

    // Scan from rr_ptr downwards in offset so the nearest candidate wins last.
    always_comb begin
        logic [2:0] sum;
        sum     = '0;
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + 3'(k);
            if (sum >= 3'd3) sum = sum - 3'd3;
            if (cand[sum[1:0]]) begin
                pick    = sum[1:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        test_req   = 1'b0;
        test_sel   = 3'b000;
        test_abort = 1'b0;
        reint      = 3'b000;
        case (state)
            IDLE: if (!bus.active && pick_ok) state_nx = REQ;
            REQ: begin
                if (abort) begin
                    test_abort = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    test_req = 1'b1;
                    test_sel = cur_oh;
                    if (bus.test_ack) state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    test_abort = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    test_sel = cur_oh;
                    if (bus.test_done || (timer == RUN_LAST)) state_nx = EVAL;
                end
            end
            EVAL: begin
                state_nx = COOL;
                if (res && (pass_cnt[cur] == PASS_LAST) && bus.dis_mask[cur])
                    reint = cur_oh;
            end
            COOL: if (timer == COOL_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= 2'd0;
            rr_ptr    <= 2'd0;
            timer     <= '0;
            res       <= 1'b0;
            retired_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                pass_cnt[i] <= 4'd0;
                fail_cnt[i] <= 4'd0;
            end
        end else begin
            case (state)
                IDLE: if (state_nx == REQ) cur <= pick;
                REQ:  timer <= '0;
                RUN: begin
                    timer <= timer + 1'b1;
                    res   <= bus.test_done & bus.test_pass;
                end
                EVAL: begin
                    timer  <= '0;
                    rr_ptr <= (cur == 2'd2) ? 2'd0 : cur + 2'd1;
                    if (res) begin
                        fail_cnt[cur] <= 4'd0;
                        if (pass_cnt[cur] == PASS_LAST) pass_cnt[cur] <= 4'd0;
                        else                            pass_cnt[cur] <= pass_cnt[cur] + 4'd1;
                    end else begin
                        pass_cnt[cur] <= 4'd0;
                        if (fail_cnt[cur] == FAIL_LAST) begin
                            fail_cnt[cur]  <= 4'd0;
                            retired_q[cur] <= 1'b1;
                        end else begin
                            fail_cnt[cur] <= fail_cnt[cur] + 4'd1;
                        end
                    end
                end
                COOL: timer <= timer + 1'b1;
                default: timer <= '0;
            endcase
        end
    end

    assign bus.test_req   = test_req;
    assign bus.test_sel   = test_sel;
    assign bus.test_abort = test_abort;
    assign bus.reint      = reint;
    assign bus.retired    = retired_q;
    assign bus.busy       = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_tmr_reint_sched.sv
`default_nettype none
// Testbench for tmr_reint_sched: a procedural timeline model predicts every
// output each cycle; directed scenarios add literal checks on top.
module tb_tmr_reint_sched;
    localparam int PASS_NEEDED = 3;
    localparam int MAX_FAILS   = 4;
    localparam int COOLDOWN    = 16;
    localparam int TIMEOUT     = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tmr_reint_sched_if bus();

    tmr_reint_sched #(
        .PASS_NEEDED(PASS_NEEDED), .MAX_FAILS(MAX_FAILS),
        .COOLDOWN(COOLDOWN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       exp_req, exp_abort, exp_busy;
    logic [2:0] exp_sel, exp_reint, exp_ret;
    int         m_pass [3];
    int         m_fail [3];
    logic [2:0] m_ret;
    int         m_start;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pass[i] = 0;
            m_fail[i] = 0;
        end
        m_ret = 3'b000; m_start = 0;
        exp_req = 0; exp_sel = 0; exp_abort = 0; exp_reint = 0; exp_busy = 0; exp_ret = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        exp_req = 0; exp_sel = 0; exp_abort = 0; exp_reint = 0; exp_busy = 1; exp_ret = m_ret;
    endtask

    function automatic int model_pick(input logic [2:0] cand);
        for (int k = 0; k < 3; k++) begin
            int idx = (m_start + k) % 3;
            if (cand[idx]) return idx;
        end
        return 0;
    endfunction

    initial begin : model_proc
        int   cur;
        logic res;
        logic ab;
        model_reset();
        forever begin
            tick();
            if (rst) begin model_reset(); continue; end
            exp_busy = 0;
            if (bus.active || (bus.dis_mask & ~m_ret) == 3'b000) continue;
            cur = model_pick(bus.dis_mask & ~m_ret);
            ab  = 0;
            forever begin
                tick();
                if (rst) break;
                if (bus.active || !bus.dis_mask[cur]) begin exp_abort = 1; ab = 1; break; end
                exp_req = 1;
                exp_sel = 3'b001 << cur;
                if (bus.test_ack) break;
            end
            if (rst) begin model_reset(); continue; end
            if (ab) continue;
            res = 0;
            for (int t = 0; t < TIMEOUT; t++) begin
                tick();
                if (rst) break;
                if (bus.active || !bus.dis_mask[cur]) begin exp_abort = 1; ab = 1; break; end
                exp_sel = 3'b001 << cur;
                if (bus.test_done) begin res = bus.test_pass; break; end
            end
            if (rst) begin model_reset(); continue; end
            if (ab) continue;
            tick();
            if (rst) begin model_reset(); continue; end
            if (res) begin
                m_fail[cur] = 0;
                m_pass[cur]++;
                if (m_pass[cur] == PASS_NEEDED) begin
                    if (bus.dis_mask[cur]) exp_reint = 3'b001 << cur;
                    m_pass[cur] = 0;
                end
            end else begin
                m_pass[cur] = 0;
                m_fail[cur]++;
                if (m_fail[cur] == MAX_FAILS) begin
                    m_ret[cur]  = 1'b1;
                    m_fail[cur] = 0;
                end
            end
            m_start = (cur + 1) % 3;
            for (int c = 0; c < COOLDOWN; c++) begin
                tick();
                if (rst) break;
            end
            if (rst) model_reset();
        end
    end

    // ---------------- per-cycle compare + event logs ----------------
    logic [2:0] req_log [$];
    logic [2:0] reint_log [$];
    int         reint_cyc = -1;
    int         abort_cnt = 0;
    logic       prev_req  = 1'b0;

    always @(negedge clk) begin
        #1;
        check("test_req",   bus.test_req,   exp_req);
        check("test_sel",   bus.test_sel,   exp_sel);
        check("test_abort", bus.test_abort, exp_abort);
        check("reint",      bus.reint,      exp_reint);
        check("retired",    bus.retired,    exp_ret);
        check("busy",       bus.busy,       exp_busy);
        if (bus.test_req && !prev_req) req_log.push_back(bus.test_sel);
        prev_req = bus.test_req;
        if (bus.reint != 3'b000) begin
            reint_log.push_back(bus.reint);
            reint_cyc = cycle_no;
        end
        if (bus.test_abort) abort_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    int req_cyc, done_cyc;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.active = 0; bus.dis_mask = 0; bus.test_ack = 0; bus.test_done = 0; bus.test_pass = 0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.test_req && n < 300) begin cyc(); n++; end
        check("req_seen", bus.test_req, 1'b1);
        req_cyc = cycle_no;
    endtask

    task automatic bist(input int ack_dly, input int done_dly, input logic pass, input logic give_done);
        wait_req();
        repeat (ack_dly) cyc();
        bus.test_ack = 1'b1;
        cyc();
        bus.test_ack = 1'b0;
        if (give_done) begin
            repeat (done_dly) cyc();
            bus.test_done = 1'b1;
            bus.test_pass = pass;
            done_cyc = cycle_no;
            cyc();
            bus.test_done = 1'b0;
            bus.test_pass = 1'b0;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n0, r0, a0, prev_done, runc;
        bus.active = 0; bus.dis_mask = 0; bus.test_ack = 0; bus.test_done = 0; bus.test_pass = 0;
        repeat (3) cyc();
        check("rst_test_req", bus.test_req, 1'b0);
        check("rst_test_sel", bus.test_sel, 3'b000);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_retired",  bus.retired,  3'b000);
        rst = 1'b0;
        cyc();

        // single module, three passes -> one reint in the EVAL after the third done
        bus.dis_mask = 3'b001;
        n0 = reint_log.size();
        prev_done = 0;
        for (int i = 0; i < 3; i++) begin
            bist(2, 3, 1'b1, 1'b1);
            if (i > 0) check("t1_gap_ge_cooldown", (req_cyc - prev_done) >= COOLDOWN, 1'b1);
            prev_done = done_cyc;
        end
        cyc(); cyc();
        check("t1_reint_count", reint_log.size() - n0, 1);
        if (reint_log.size() > n0) check("t1_reint_val", reint_log[n0], 3'b001);
        check("t1_reint_cycle", reint_cyc, done_cyc + 1);
        bus.dis_mask = 3'b000;
        repeat (20) cyc();

        // all three disabled, all pass -> round-robin order
        apply_reset();
        r0 = req_log.size();
        n0 = reint_log.size();
        bus.dis_mask = 3'b111;
        for (int i = 0; i < 9; i++) bist(1, 1, 1'b1, 1'b1);
        cyc(); cyc();
        check("t2_req_count_ge4", req_log.size() - r0 >= 4, 1'b1);
        if (req_log.size() - r0 >= 4) begin
            check("t2_sel0", req_log[r0],     3'b001);
            check("t2_sel1", req_log[r0 + 1], 3'b010);
            check("t2_sel2", req_log[r0 + 2], 3'b100);
            check("t2_sel3", req_log[r0 + 3], 3'b001);
        end
        check("t2_reint_count", reint_log.size() - n0, 3);
        if (reint_log.size() - n0 == 3) begin
            check("t2_reint0", reint_log[n0],     3'b001);
            check("t2_reint1", reint_log[n0 + 1], 3'b010);
            check("t2_reint2", reint_log[n0 + 2], 3'b100);
        end
        bus.dis_mask = 3'b000;

        // four fails -> retired, then silence
        apply_reset();
        bus.dis_mask = 3'b010;
        for (int i = 0; i < MAX_FAILS; i++) bist(0, 2, 1'b0, 1'b1);
        cyc(); cyc();
        check("t3_retired", bus.retired, 3'b010);
        r0 = req_log.size();
        repeat (40) cyc();
        check("t3_no_more_req", req_log.size() - r0, 0);
        check("t3_idle", bus.busy, 1'b0);

        // ack but no done -> 64 RUN cycles then a fail
        apply_reset();
        bus.dis_mask = 3'b100;
        bist(1, 0, 1'b0, 1'b0);
        runc = 0;
        while (bus.test_sel != 3'b000 && runc < 200) begin runc++; cyc(); end
        check("t4_run_cycles", runc, TIMEOUT);
        cyc();
        check("t4_model_fail_cnt", m_fail[2], 1);
        check("t4_cooling_busy", bus.busy, 1'b1);
        bus.dis_mask = 3'b000;
        repeat (20) cyc();

        // abort during RUN keeps counters and rr pointer
        apply_reset();
        bus.dis_mask = 3'b011;
        bist(1, 1, 1'b1, 1'b1);
        bist(1, 1, 1'b1, 1'b1);
        a0 = abort_cnt;
        n0 = reint_log.size();
        wait_req();
        check("t5_abort_target", bus.test_sel, 3'b001);
        bus.test_ack = 1'b1;
        cyc();
        bus.test_ack = 1'b0;
        cyc(); cyc();
        bus.active = 1'b1;
        cyc();
        check("t5_abort_pulse", abort_cnt - a0, 1);
        check("t5_idle_after_abort", bus.busy, 1'b0);
        repeat (5) cyc();
        bus.active = 1'b0;
        wait_req();
        check("t5_same_module_first", bus.test_sel, 3'b001);
        for (int i = 0; i < 3; i++) bist(1, 1, 1'b1, 1'b1);
        cyc(); cyc();
        check("t5_reint_count", reint_log.size() - n0, 1);
        if (reint_log.size() > n0) check("t5_reint_val", reint_log[n0], 3'b001);
        bus.dis_mask = 3'b000;

        // asynchronous reset during REQ
        apply_reset();
        bus.dis_mask = 3'b001;
        bist(1, 1, 1'b1, 1'b1);
        wait_req();
        a0 = abort_cnt;
        rst = 1'b1;
        #1;
        check("t6_req_drop", bus.test_req, 1'b0);
        cyc(); cyc();
        check("t6_no_abort", abort_cnt - a0, 0);
        check("t6_retired_clear", bus.retired, 3'b000);
        rst = 1'b0;
        n0 = reint_log.size();
        bist(1, 1, 1'b1, 1'b1);
        bist(1, 1, 1'b1, 1'b1);
        cyc(); cyc();
        check("t6_pass_cnt_cleared", reint_log.size() - n0, 0);
        bist(1, 1, 1'b1, 1'b1);
        cyc(); cyc();
        check("t6_reint_after_three", reint_log.size() - n0, 1);
        bus.dis_mask = 3'b000;
        repeat (20) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
